// File: rtl/seg_scan_decoder.sv
// Receiving end of a scanned, active-low 8-position 7-segment bus. It samples
// led_en/led_cx, waits for each dwell to settle, decodes the segments back to
// digit codes and publishes one coherent 8-digit frame with sticky error
// flags and scan-loss detection.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 4000000,
  parameter int unsigned CNT_W   = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led_en,
  input  logic [7:0]  led_cx,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic        frame_valid,
  output logic [7:0]  blank_mask,
  output logic        err_invalid,
  output logic        err_multi,
  output logic        scan_lost
);

  localparam int unsigned SW = $clog2(SETTLE + 1);

  // Segment pattern {A..G} (active-low) to digit code; F = blank, E = invalid.
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = 4'h0;
      7'b1001111: seg_decode = 4'h1;
      7'b0010010: seg_decode = 4'h2;
      7'b0000110: seg_decode = 4'h3;
      7'b1001100: seg_decode = 4'h4;
      7'b0100100: seg_decode = 4'h5;
      7'b0100000: seg_decode = 4'h6;
      7'b0001111: seg_decode = 4'h7;
      7'b0000000: seg_decode = 4'h8;
      7'b0000100: seg_decode = 4'h9;
      7'b1111111: seg_decode = 4'hF;
      default:    seg_decode = 4'hE;
    endcase
  endfunction

  logic [7:0]    en_m_q, en_s_q, cx_m_q, cx_s_q, en_p_q, cx_p_q;
  logic [SW-1:0] settle_q, settle_d;
  logic          captured_q, captured_d;
  logic [7:0]    seen_q, seen_d;
  logic [31:0]   stage_q, stage_d;
  logic [7:0]    sblank_q, sblank_d;
  logic          pend_q, pend_d;
  logic [31:0]   digits_q, digits_d;
  logic [7:0]    blank_q, blank_d;
  logic          fv_q, fv_d;
  logic          err_inv_q, err_inv_d;
  logic          err_multi_q, err_multi_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic          lost_q, lost_d;

  logic       same, one_hot, multi, at_settle, capture;
  logic [7:0] en_n;
  logic [2:0] pos;
  logic [3:0] code;

  // Dwell qualification, position encode and decode of the synced bus.
  always_comb begin
    same      = ({en_s_q, cx_s_q} == {en_p_q, cx_p_q});
    en_n      = ~en_s_q;
    one_hot   = (en_n != 8'd0) && ((en_n & (en_n - 8'd1)) == 8'd0);
    multi     = (en_n != 8'd0) && !one_hot;
    at_settle = same && (settle_q == SW'(SETTLE - 1));
    capture   = at_settle && !captured_q && one_hot;
    code      = seg_decode(cx_s_q[7:1]);
    pos       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (en_n[i]) pos = 3'(i);
    end
  end

  // Next-state for settle tracking, staging, frame publish, errors and timeout.
  always_comb begin
    settle_d   = settle_q;
    captured_d = captured_q;
    if (same) begin
      if (settle_q != SW'(SETTLE)) settle_d = settle_q + SW'(1);
    end else begin
      settle_d   = '0;
      captured_d = 1'b0;
    end
    if (capture) captured_d = 1'b1;

    seen_d   = pend_q ? 8'd0 : seen_q;
    stage_d  = stage_q;
    sblank_d = sblank_q;
    if (capture) begin
      seen_d[pos]               = 1'b1;
      stage_d[{pos, 2'b00} +: 4] = code;
      sblank_d[pos]             = (code == 4'hF);
    end
    pend_d = capture && (seen_d == 8'hFF);

    // Staging is published one cycle after the completing capture.
    digits_d = pend_q ? stage_q : digits_q;
    blank_d  = pend_q ? sblank_q : blank_q;
    fv_d     = pend_q;

    // Set has priority over clear.
    err_inv_d   = (capture && (code == 4'hE)) || (err_inv_q && !err_clr);
    err_multi_d = (at_settle && multi) || (err_multi_q && !err_clr);

    if (capture) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != CNT_W'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    lost_d = (to_cnt_d == CNT_W'(TIMEOUT));
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_m_q      <= 8'hFF;
      en_s_q      <= 8'hFF;
      cx_m_q      <= 8'hFF;
      cx_s_q      <= 8'hFF;
      en_p_q      <= 8'hFF;
      cx_p_q      <= 8'hFF;
      settle_q    <= '0;
      captured_q  <= 1'b0;
      seen_q      <= 8'd0;
      stage_q     <= 32'd0;
      sblank_q    <= 8'd0;
      pend_q      <= 1'b0;
      digits_q    <= 32'd0;
      blank_q     <= 8'd0;
      fv_q        <= 1'b0;
      err_inv_q   <= 1'b0;
      err_multi_q <= 1'b0;
      to_cnt_q    <= '0;
      lost_q      <= 1'b0;
    end else begin
      en_m_q      <= led_en;
      en_s_q      <= en_m_q;
      cx_m_q      <= led_cx;
      cx_s_q      <= cx_m_q;
      en_p_q      <= en_s_q;
      cx_p_q      <= cx_s_q;
      settle_q    <= settle_d;
      captured_q  <= captured_d;
      seen_q      <= seen_d;
      stage_q     <= stage_d;
      sblank_q    <= sblank_d;
      pend_q      <= pend_d;
      digits_q    <= digits_d;
      blank_q     <= blank_d;
      fv_q        <= fv_d;
      err_inv_q   <= err_inv_d;
      err_multi_q <= err_multi_d;
      to_cnt_q    <= to_cnt_d;
      lost_q      <= lost_d;
    end
  end

  assign digits      = digits_q;
  assign frame_valid = fv_q;
  assign blank_mask  = blank_q;
  assign err_invalid = err_inv_q;
  assign err_multi   = err_multi_q;
  assign scan_lost   = lost_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment interface (led_en / led_cx, active-low, 8 positions).
- Samples the scanned bus and decodes each segment pattern back to a 4-bit digit code.
- Assembles one coherent 8-digit frame, with settle filtering, error flags and scan-loss detection.
- Used for on-board loopback self-test of display drivers and as a bench monitor.

Parameters:
- SETTLE, 16: consecutive identical cycles of (en,cx) required before a capture.
- TIMEOUT, 4000000: cycles without a capture before scan_lost asserts.
- CNT_W, 23: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; synchronous, active-high.
- led_en  input  8  digit enables, active-low; bit i low selects position i.
- led_cx  input  8  segments, active-low, {A,B,C,D,E,F,G,DP} = bits [7:0].
- err_clr  input  1  single-cycle clear of the sticky error flags.
- digits  output  32  frame snapshot; nibble i = code of position i.
- frame_valid  output  1  one-cycle pulse when digits updates.
- blank_mask  output  8  bit i = 1 when position i was blank in the snapshot.
- err_invalid  output  1  sticky; set when an undecodable pattern is captured.
- err_multi  output  1  sticky; set when more than one enable is low.
- scan_lost  output  1  high while no capture has occurred for TIMEOUT cycles.

Behaviour:
- Reset (synchronous, active-high, one clock) clears all state:
  - Outputs: digits=0, blank_mask=0, frame_valid=0, err_invalid=0, err_multi=0, scan_lost=0.
  - Internal: seen=0, settle count=0, captured=0, timeout count=0, synchroniser stages=8'hFF.
  - rst mid-dwell discards the partial frame.
- Synchroniser: two flop stages on led_en and led_cx. All logic uses the synced values en_s and cx_s. Synchroniser latency is 2 cycles.
- Dwell tracking:
  - If {en_s,cx_s} equals the previous cycle's value, settle count increments, saturating at SETTLE.
  - Otherwise settle count=0 and captured=0.
- Capture fires in the cycle settle count reaches SETTLE-1, only if captured=0 and en_s has exactly one zero bit.
  - Sets captured=1, so there is at most one capture per dwell.
  - Writes decoded code to staging nibble[pos] and sets seen[pos].
  - Clears the timeout count and scan_lost.
  - A re-capture of an already-seen position overwrites the staging nibble.
- Decode: cx_s[0] (DP) is ignored; match on cx_s[7:1].
  - Codes 0..9 for: 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100.
  - 1111111 gives code 4'hF and sets staging blank bit.
  - Any other pattern gives code 4'hE and sets err_invalid.
- Invalid enables:
  - en_s == 8'hFF: idle; no capture, no error.
  - Two or more zeros: no capture; err_multi set once the condition has been stable for SETTLE cycles.
- Frame completion: in the cycle after the capture that makes seen == 8'hFF:
  - digits and blank_mask load from staging.
  - frame_valid pulses for 1 cycle.
  - seen clears.
  - Staging is retained; digits holds until the next frame.
- Timeout:
  - Count increments each cycle without a capture, saturating.
  - scan_lost=1 when the count reaches TIMEOUT; it stays high until the next capture.
- err_clr clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- Total latency from led_en/led_cx change to capture: 2 + SETTLE cycles.

Test Plan (SETTLE=4, TIMEOUT=64):
- Reset: drive rst 1 cycle, then en=8'hFF for 100 cycles.
  - digits=0, no frame_valid, err flags 0.
  - scan_lost=1 from cycle 64 after rst release.
- Normal frame: scan positions 0..7 showing 0,4,0,3,1,2,2,0, each held 10 cycles.
  - One frame_valid pulse; digits=32'h02213040, blank_mask=0.
- Glitch and settle: position 2 shows 8, but cx toggles every 3 cycles for 12 cycles before settling on 5.
  - Captured nibble is 5, never 8.
  - Exactly one capture in that dwell.
- Blank/invalid/DP: position 1 cx=8'hFF, position 3 cx=8'b0110_0010, position 5 cx=8'b0000_0010 (0 with DP).
  - Nibbles F, E, 0; blank_mask bit1=1; err_invalid=1.
- Multi-enable and clear: en=8'b1111_1100 for 10 cycles.
  - err_multi=1, no capture, seen unchanged.
  - err_clr pulse sets err_multi=0.
  - err_clr coincident with a new set leaves the flag at 1.
- Reset mid-frame and timeout recovery:
  - rst after 4 positions, then a full scan: next frame contains only post-reset data.
  - Stall scanning 70 cycles: scan_lost=1.
  - Next capture drops scan_lost to 0.
